// File: rtl/mfp_ahb_lite_master_bridge.sv
// mfp_ahb_lite_master_bridge
//
// AHB-Lite initiator for DMA and debug agents. Each command from a
// valid/ready stream becomes one single-beat AHB-Lite transfer. Each command
// returns exactly one response, in issue order. The address and data phases
// are pipelined through two slots. A is the address phase and D is the data
// phase, so a zero-wait slave sees one transfer per cycle.
//
// Ports:
//   HCLK, HRESET             clock; synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_addr, cmd_write,     byte address, direction, size (0/1/2) and
//   cmd_size, cmd_wdata      lane-aligned write data
//   rsp_valid / rsp_ready    response handshake (head of response FIFO)
//   rsp_rdata, rsp_err       read data (0 for writes/errors) and error flag
//   HADDR, HSIZE, HWRITE,    AHB-Lite address/control, driven from slot A
//   HTRANS
//   HWDATA                   AHB-Lite write data, driven from slot D
//   HBURST, HMASTLOCK, HPROT constant SINGLE / unlocked / data privileged
//   HRDATA, HREADY, HRESP    AHB-Lite slave response
module mfp_ahb_lite_master_bridge #(
  parameter int RSP_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Address-phase slot
  logic        a_valid, a_write, a_cancel;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_size;

  // Data-phase slot
  logic        d_valid, d_write, d_cancel;
  logic [31:0] d_wdata;

  // Response FIFO, each entry is {err, rdata}
  logic [32:0]   fifo_mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;

  logic          err_pend;
  logic [OW-1:0] occupancy;
  logic          cmd_fire, cmd_illegal, push, pop;
  logic [32:0]   push_entry;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every command held in A or D will still need a FIFO slot, so they are
  // counted here. This keeps the FIFO from ever overflowing without having to
  // stall the bus. HRESP also blocks acceptance. This covers both ERROR cycles
  // and guarantees that nothing new enters A behind a failing transfer.
  assign occupancy = OW'(a_valid) + OW'(d_valid) + OW'(fifo_count);
  assign cmd_ready = !HRESET && !HRESP && (!a_valid || HREADY) &&
                     (occupancy < OW'(RSP_DEPTH));
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Misaligned or oversized commands never reach the bus. They carry a
  // cancel flag through the pipeline and complete with an error.
  always_comb begin
    cmd_illegal = 1'b0;
    case (cmd_size)
      3'd0:    cmd_illegal = 1'b0;
      3'd1:    cmd_illegal = cmd_addr[0];
      3'd2:    cmd_illegal = |cmd_addr[1:0];
      default: cmd_illegal = 1'b1;
    endcase
  end

  assign push       = HREADY && d_valid;
  assign pop        = rsp_valid && rsp_ready;
  assign push_entry = {d_cancel | HRESP, (d_write | d_cancel) ? 32'd0 : HRDATA};

  // Pipeline advance. A command can be loaded into an empty A even while the
  // slave is stalling. In that case the bus showed IDLE, so the new address
  // phase simply waits for HREADY. During a two-cycle ERROR, err_pend cancels
  // whatever A holds as it moves into D.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid  <= 1'b0;
      a_write  <= 1'b0;
      a_cancel <= 1'b0;
      a_addr   <= '0;
      a_wdata  <= '0;
      a_size   <= '0;
      d_valid  <= 1'b0;
      d_write  <= 1'b0;
      d_cancel <= 1'b0;
      d_wdata  <= '0;
      err_pend <= 1'b0;
    end else begin
      if (HREADY) begin
        d_valid  <= a_valid;
        d_write  <= a_write;
        d_wdata  <= a_wdata;
        d_cancel <= a_cancel | err_pend;
        err_pend <= 1'b0;
      end else if (d_valid && HRESP && !d_cancel) begin
        err_pend <= 1'b1;
      end
      if (cmd_fire) begin
        a_valid  <= 1'b1;
        a_addr   <= cmd_addr;
        a_write  <= cmd_write;
        a_size   <= cmd_size;
        a_wdata  <= cmd_wdata;
        a_cancel <= cmd_illegal;
      end else if (HREADY) begin
        a_valid  <= 1'b0;
        a_addr   <= '0;
        a_write  <= 1'b0;
        a_size   <= '0;
        a_wdata  <= '0;
        a_cancel <= 1'b0;
      end
    end
  end

  // The response storage has no reset. Stale entries are unreachable because
  // the pointers and count are reset, and the outputs are gated by rsp_valid.
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign HADDR     = a_addr;
  assign HSIZE     = a_size;
  assign HWRITE    = a_write;
  assign HTRANS    = (a_valid && !a_cancel && !err_pend) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HWDATA    = d_wdata;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;

  assign rsp_valid = (fifo_count != '0);
  assign {rsp_err, rsp_rdata} = rsp_valid ? fifo_mem[rd_ptr] : 33'd0;

endmodule

// File: tb/tb_mfp_ahb_lite_master_bridge.sv
// tb_mfp_ahb_lite_master_bridge
//
// Scenario-driven bench for the AHB-Lite master bridge. Inputs change on the
// falling edge. Registered outputs are checked at the falling edge, and
// handshakes are sampled 1 ns later. Each accepted command pushes its
// expected response onto exp_q. Each response the DUT hands over is collected
// in act_q. Every scenario then compares the two queues in order.
module tb_mfp_ahb_lite_master_bridge;

  logic        HCLK, HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [1:0]  HTRANS;
  logic [3:0]  HPROT;

  int          tests_run;
  int          tests_failed;
  logic [32:0] exp_q[$];
  logic [32:0] act_q[$];
  logic        acc;
  logic [31:0] dp_addr;
  bit          auto_rdata;

  mfp_ahb_lite_master_bridge #(.RSP_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .HADDR(HADDR), .HSIZE(HSIZE), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100000 ns, required earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock. This records the command handshake and any response
  // handed over at the coming edge. It also tracks which address is entering
  // its data phase, so the optional slave model can return address-derived
  // read data.
  task automatic clk_step();
    logic [31:0] nxt;
    bit          xfer;
    #1;
    acc  = cmd_valid && cmd_ready;
    xfer = (HTRANS == 2'b10) && HREADY;
    nxt  = HADDR;
    if (rsp_valid && rsp_ready) act_q.push_back({rsp_err, rsp_rdata});
    @(negedge HCLK);
    if (xfer) dp_addr = nxt;
    if (auto_rdata) HRDATA = dp_addr ^ 32'h5A5A_0000;
  endtask

  task automatic set_idle();
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_size  = '0;
    cmd_wdata = '0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    rsp_ready = 1'b1;
  endtask

  task automatic set_cmd(input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
  endtask

  task automatic test_reset();
    act_q.delete();
    exp_q.delete();
    HRESET = 1'b1;
    set_cmd(1'b0, 32'h10, 3'd2, 32'h0);
    clk_step();
    clk_step();
    tests_run++;
    if (acc !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset cmd_ready: got %b, expected 0", acc);
    end
    tests_run++;
    if ({HTRANS, HADDR, HSIZE, HWRITE, HWDATA} !== 70'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset bus: got HTRANS=%b HADDR=%h HSIZE=%0d HWRITE=%b HWDATA=%h, expected all 0",
               HTRANS, HADDR, HSIZE, HWRITE, HWDATA);
    end
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset rsp: got valid=%b err=%b rdata=%h, expected 0 0 0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    tests_run++;
    if ({HBURST, HMASTLOCK, HPROT} !== {3'b000, 1'b0, 4'b0011}) begin
      tests_failed++;
      $display("[TB] FAIL constants: got HBURST=%b HMASTLOCK=%b HPROT=%b, expected 000 0 0011",
               HBURST, HMASTLOCK, HPROT);
    end
    HRESET = 1'b0;
    set_idle();
    clk_step();
    tests_run++;
    if (HTRANS !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL post_reset HTRANS: got %b, expected 00", HTRANS);
    end
  endtask

  task automatic test_single_read();
    logic [32:0] got, want;
    set_cmd(1'b0, 32'h1FC0_0010, 3'd2, 32'h0);
    clk_step();
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_read accept: got %b, expected 1", acc);
    end
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    cmd_valid = 1'b0;
    HRDATA    = 32'hDEAD_BEEF;
    tests_run++;
    if ({HTRANS, HADDR, HWRITE, HSIZE} !== {2'b10, 32'h1FC0_0010, 1'b0, 3'd2}) begin
      tests_failed++;
      $display("[TB] FAIL single_read addr_phase: got HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%0d, expected 10 1fc00010 0 2",
               HTRANS, HADDR, HWRITE, HSIZE);
    end
    clk_step();
    tests_run++;
    if ({HTRANS, rsp_valid} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL single_read data_phase: got HTRANS=%b rsp_valid=%b, expected 00 0", HTRANS, rsp_valid);
    end
    clk_step();
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_read latency: got rsp_valid=%b two edges after accept, expected 1", rsp_valid);
    end
    for (int i = 0; i < 20 && act_q.size() < exp_q.size(); i++) clk_step();
    tests_run++;
    if (act_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL single_read rsp_count: got %0d, expected %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got  = act_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL single_read rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                 got[32], got[31:0], want[32], want[31:0]);
      end
    end
    act_q.delete();
    exp_q.delete();
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic [32:0] got, want;
    for (int k = 0; k <= 5; k++) begin
      if (k >= 1 && k <= 4) begin
        tests_run++;
        if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'((k - 1) * 4), 1'b1}) begin
          tests_failed++;
          $display("[TB] FAIL b2b addr k=%0d: got HTRANS=%b HADDR=%h HWRITE=%b, expected 10 %h 1",
                   k, HTRANS, HADDR, HWRITE, 32'((k - 1) * 4));
        end
      end
      if (k >= 2) begin
        tests_run++;
        if (HWDATA !== 32'(17 * (k - 1))) begin
          tests_failed++;
          $display("[TB] FAIL b2b HWDATA k=%0d: got %h, expected %h", k, HWDATA, 32'(17 * (k - 1)));
        end
      end
      if (k == 5) begin
        tests_run++;
        if (HTRANS !== 2'b00) begin
          tests_failed++;
          $display("[TB] FAIL b2b trailing HTRANS: got %b, expected 00", HTRANS);
        end
      end
      if (k < 4) set_cmd(1'b1, 32'(k * 4), 3'd2, 32'(17 * (k + 1)));
      else cmd_valid = 1'b0;
      clk_step();
      if (k < 4) begin
        tests_run++;
        if (acc !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL b2b accept k=%0d: got %b, expected 1", k, acc);
        end
        exp_q.push_back(33'd0);
      end
    end
    for (int i = 0; i < 20 && act_q.size() < exp_q.size(); i++) clk_step();
    tests_run++;
    if (act_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL b2b rsp_count: got %0d, expected %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got  = act_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL b2b rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                 got[32], got[31:0], want[32], want[31:0]);
      end
    end
    act_q.delete();
    exp_q.delete();
    set_idle();
  endtask

  task automatic test_wait_states();
    logic [32:0] got, want;
    set_cmd(1'b0, 32'h0000_0200, 3'd2, 32'h0);
    clk_step();
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wait read accept: got %b, expected 1", acc);
    end
    exp_q.push_back({1'b0, 32'h1234_5678});
    set_cmd(1'b1, 32'h0000_0204, 3'd2, 32'hCAFE_F00D);
    HRDATA = 32'hBAD0_BAD0;
    clk_step();
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wait write accept: got %b, expected 1", acc);
    end
    exp_q.push_back(33'd0);
    for (int w = 0; w < 3; w++) begin
      HREADY = 1'b0;
      set_cmd(1'b0, 32'h0000_0208, 3'd2, 32'h0);
      tests_run++;
      if ({HTRANS, HADDR, HWRITE, HSIZE, rsp_valid} !== {2'b10, 32'h0000_0204, 1'b1, 3'd2, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL wait hold w=%0d: got HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%0d rsp_valid=%b, expected 10 00000204 1 2 0",
                 w, HTRANS, HADDR, HWRITE, HSIZE, rsp_valid);
      end
      clk_step();
      tests_run++;
      if (acc !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL wait stall accept w=%0d: got %b, expected 0", w, acc);
      end
    end
    cmd_valid = 1'b0;
    HREADY    = 1'b1;
    HRDATA    = 32'h1234_5678;
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wait early rsp: got rsp_valid=%b four edges after accept, expected 0", rsp_valid);
    end
    clk_step();
    HRDATA = 32'hBAD0_BAD0;
    tests_run++;
    if ({rsp_valid, HWDATA, HTRANS} !== {1'b1, 32'hCAFE_F00D, 2'b00}) begin
      tests_failed++;
      $display("[TB] FAIL wait completion: got rsp_valid=%b HWDATA=%h HTRANS=%b, expected 1 cafef00d 00",
               rsp_valid, HWDATA, HTRANS);
    end
    for (int i = 0; i < 20 && act_q.size() < exp_q.size(); i++) clk_step();
    tests_run++;
    if (act_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL wait rsp_count: got %0d, expected %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got  = act_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL wait rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                 got[32], got[31:0], want[32], want[31:0]);
      end
    end
    act_q.delete();
    exp_q.delete();
    set_idle();
  endtask

  task automatic test_error();
    logic [32:0] got, want;
    HRDATA = 32'hBAD0_BAD0;
    set_cmd(1'b1, 32'h1F80_0000, 3'd2, 32'h55);
    clk_step();
    exp_q.push_back({1'b1, 32'h0});
    set_cmd(1'b0, 32'h0000_0100, 3'd2, 32'h0);
    clk_step();
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL error read accept: got %b, expected 1", acc);
    end
    exp_q.push_back({1'b1, 32'h0});
    cmd_valid = 1'b0;
    HREADY    = 1'b0;
    HRESP     = 1'b1;
    tests_run++;
    if ({HTRANS, HADDR} !== {2'b10, 32'h0000_0100}) begin
      tests_failed++;
      $display("[TB] FAIL error cycle1: got HTRANS=%b HADDR=%h, expected 10 00000100", HTRANS, HADDR);
    end
    clk_step();
    HREADY = 1'b1;
    set_cmd(1'b0, 32'h0000_0104, 3'd2, 32'h0);
    tests_run++;
    if (HTRANS !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL error cycle2 HTRANS: got %b, expected 00", HTRANS);
    end
    clk_step();
    tests_run++;
    if (acc !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL error cycle2 accept: got %b, expected 0", acc);
    end
    cmd_valid = 1'b0;
    HRESP     = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (HTRANS !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL error reissue k=%0d: got HTRANS=%b HADDR=%h, expected 00", k, HTRANS, HADDR);
      end
      clk_step();
    end
    for (int i = 0; i < 20 && act_q.size() < exp_q.size(); i++) clk_step();
    tests_run++;
    if (act_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL error rsp_count: got %0d, expected %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got  = act_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL error rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                 got[32], got[31:0], want[32], want[31:0]);
      end
    end
    act_q.delete();
    exp_q.delete();
    set_idle();
  endtask

  task automatic test_illegal();
    logic [32:0] got, want;
    HRDATA = 32'hFFFF_FFFF;
    set_cmd(1'b0, 32'h0000_0002, 3'd2, 32'h0);
    clk_step();
    exp_q.push_back({1'b1, 32'h0});
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) set_cmd(1'b0, 32'h0000_0000, 3'd3, 32'h0);
      else cmd_valid = 1'b0;
      tests_run++;
      if (HTRANS !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL illegal on_bus k=%0d: got HTRANS=%b HADDR=%h, expected 00", k, HTRANS, HADDR);
      end
      clk_step();
      if (k == 1) begin
        tests_run++;
        if (acc !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL illegal accept: got %b, expected 1", acc);
        end
        exp_q.push_back({1'b1, 32'h0});
      end
    end
    for (int i = 0; i < 20 && act_q.size() < exp_q.size(); i++) clk_step();
    tests_run++;
    if (act_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL illegal rsp_count: got %0d, expected %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got  = act_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL illegal rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                 got[32], got[31:0], want[32], want[31:0]);
      end
    end
    act_q.delete();
    exp_q.delete();
    set_idle();
  endtask

  task automatic test_backpressure();
    logic [32:0] got, want;
    int          n_acc;
    n_acc      = 0;
    rsp_ready  = 1'b0;
    auto_rdata = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_cmd(1'b0, 32'h0000_0300 + 32'(n_acc * 4), 3'd2, 32'h0);
      clk_step();
      if (acc) begin
        exp_q.push_back({1'b0, cmd_addr ^ 32'h5A5A_0000});
        n_acc++;
      end
    end
    tests_run++;
    if (n_acc != 4) begin
      tests_failed++;
      $display("[TB] FAIL backpressure accepted: got %0d, expected 4", n_acc);
    end
    tests_run++;
    if ({acc, rsp_valid} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL backpressure full: got cmd_ready=%b rsp_valid=%b, expected 0 1", acc, rsp_valid);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && act_q.size() < exp_q.size(); i++) clk_step();
    auto_rdata = 1'b0;
    tests_run++;
    if (act_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL backpressure rsp_count: got %0d, expected %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      got  = act_q.pop_front();
      want = exp_q.pop_front();
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL backpressure rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                 got[32], got[31:0], want[32], want[31:0]);
      end
    end
    act_q.delete();
    exp_q.delete();
    set_idle();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    set_cmd(1'b1, 32'h0000_0400, 3'd2, 32'h77);
    clk_step();
    set_cmd(1'b0, 32'h0000_0404, 3'd2, 32'h0);
    clk_step();
    cmd_valid = 1'b0;
    clk_step();
    HREADY = 1'b0;
    clk_step();
    HRESET = 1'b1;
    set_cmd(1'b0, 32'h0000_0408, 3'd2, 32'h0);
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset queued: got rsp_valid=%b before reset, expected 1", rsp_valid);
    end
    clk_step();
    tests_run++;
    if (acc !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset cmd_ready: got %b during reset, expected 0", acc);
    end
    HRESET = 1'b0;
    set_idle();
    tests_run++;
    if ({HTRANS, HADDR, HSIZE, HWRITE, HWDATA, rsp_valid, rsp_err, rsp_rdata} !== 104'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset outputs: got HTRANS=%b HADDR=%h HSIZE=%0d HWRITE=%b HWDATA=%h rsp_valid=%b rsp_err=%b rsp_rdata=%h, expected all 0",
               HTRANS, HADDR, HSIZE, HWRITE, HWDATA, rsp_valid, rsp_err, rsp_rdata);
    end
    for (int k = 0; k < 4; k++) clk_step();
    tests_run++;
    if (act_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset stale rsp: got %0d responses, expected 0", act_q.size());
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    acc          = 1'b0;
    dp_addr      = '0;
    auto_rdata   = 1'b0;
    HRESET       = 1'b1;
    set_idle();
    @(negedge HCLK);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_illegal();
    test_backpressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
